ssd_debug_ctrl: RTL and testbench

Front-panel controller for the datapath debug display. It steps the 4-bit probe select driven into the debug value mux from two push-buttons, and converts the returned 13-bit probe value to decimal using sequential double-dabble. It time-multiplexes the four decimal digits onto a common-anode 4-digit seven-segment display. It sits at the board top level, between the buttons/display pins and the debug mux.

---
 rtl/ssd_pkg.sv | 27 ++
 rtl/ssd_digit_decoder.sv | 30 +++
 rtl/ssd_debug_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_ssd_debug_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants for the debug seven-segment display controller.
package ssd_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BIN_WIDTH  = 13;
  localparam int unsigned BCD_WIDTH  = 4 * NUM_DIGITS;
  localparam int unsigned BitCntW    = $clog2(BIN_WIDTH);

  // Conversion FSM states
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/ssd_digit_decoder.sv
// BCD digit to active-low seven-segment pattern, with forced blanking.
module ssd_digit_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Segment lookup; non-decimal codes show nothing
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/ssd_debug_ctrl.sv
// Debug display front panel: button-stepped probe select, binary-to-BCD
// conversion of the probed value and a multiplexed 4-digit display scan.
module ssd_debug_ctrl
  import ssd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REFRESH_DIV     = 100000,
  parameter int unsigned NUM_SEL         = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_next,
  input  logic                  btn_prev,
  input  logic [BIN_WIDTH-1:0]  value_in,
  output logic [3:0]            sel_out,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            cathode
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RefW = $clog2(REFRESH_DIV + 1);
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_DIV - 1);
  localparam logic [3:0]      SelLast = 4'(NUM_SEL - 1);

  // ---------------------------------------------------------------------------
  // Buttons: bit 0 = next, bit 1 = prev
  // ---------------------------------------------------------------------------
  logic [1:0]     btn_raw;
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     acc_q, acc_d;
  logic [1:0]     pulse_q, pulse_d;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];

  assign btn_raw = {btn_prev, btn_next};

  // Debounce: accept a new level only after DEBOUNCE_CYCLES differing samples
  always_comb begin
    acc_d   = acc_q;
    pulse_d = '0;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != acc_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          acc_d[i]   = sync2_q[i];
          pulse_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // Synchronisers, accepted levels and step pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      acc_q       <= '0;
      pulse_q     <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      acc_q       <= acc_d;
      pulse_q     <= pulse_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Probe select
  // ---------------------------------------------------------------------------
  logic [3:0] sel_q, sel_d;
  logic       sel_change;

  // Wrapping step; simultaneous next and prev cancel out
  always_comb begin
    sel_d = sel_q;
    if (pulse_q == 2'b01) begin
      sel_d = (sel_q == SelLast) ? 4'd0 : sel_q + 4'd1;
    end else if (pulse_q == 2'b10) begin
      sel_d = (sel_q == 4'd0) ? SelLast : sel_q - 4'd1;
    end
  end

  assign sel_change = (sel_d != sel_q);

  // ---------------------------------------------------------------------------
  // Double-dabble conversion
  // ---------------------------------------------------------------------------
  logic [1:0]           state_q, state_d;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_WIDTH-1:0] bcd_q, bcd_d, bcd_adj;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BCD_WIDTH-1:0] digits_q, digits_d;

  // Conversion sequencing; a select change restarts it without touching the display
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    digits_d  = digits_q;
    bcd_adj   = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    case (state_q)
      StIdle: begin
        shift_d   = value_in;
        bcd_d     = '0;
        bit_cnt_d = '0;
        state_d   = StShift;
      end
      StShift: begin
        {bcd_d, shift_d} = {bcd_adj[BCD_WIDTH-2:0], shift_q, 1'b0};
        if (bit_cnt_q == BitCntW'(BIN_WIDTH - 1)) begin
          state_d = StDone;
        end else begin
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
        end
      end
      StDone: begin
        digits_d = bcd_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (sel_change) begin
      state_d  = StIdle;
      digits_d = digits_q;
    end
  end

  // Select, conversion datapath and displayed digits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      state_q   <= StIdle;
      shift_q   <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      digits_q  <= '0;
    end else begin
      sel_q     <= sel_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      digits_q  <= digits_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic [RefW-1:0]       ref_q, ref_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            cathode_q, cathode_d;
  logic [NUM_DIGITS-1:0] nz;
  logic [3:0]            cur_digit;
  logic                  blank;

  // Refresh divider and digit index
  always_comb begin
    ref_d = ref_q + RefW'(1);
    idx_d = idx_q;
    if (ref_q == RefLast) begin
      ref_d = '0;
      idx_d = idx_q + IdxW'(1);
    end
  end

  // Nonzero flags per digit for leading-zero blanking
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nz[i] = (digits_q[4*i +: 4] != 4'd0);
    end
  end

  assign cur_digit = digits_q[{idx_q, 2'b00} +: 4];
  // Blank when nothing nonzero sits at or above this position; digit 0 always shows
  assign blank     = (idx_q != '0) && ((nz >> idx_q) == '0);
  assign anode_d   = ~(NUM_DIGITS'(1) << idx_q);

  ssd_digit_decoder u_decoder (
    .digit_i (cur_digit),
    .blank_i (blank),
    .seg_o   (cathode_d)
  );

  // Scan state and registered display drive (anode and cathode change together)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q     <= '0;
      idx_q     <= '0;
      anode_q   <= 4'b1110;
      cathode_q <= SEG_0;
    end else begin
      ref_q     <= ref_d;
      idx_q     <= idx_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign sel_out = sel_q;
  assign anode   = anode_q;
  assign cathode = cathode_q;

endmodule

// File: tb/tb_ssd_debug_ctrl.sv
// Scoreboard bench for ssd_debug_ctrl: stimulus queues expected {anode,
// cathode, sel}; the monitor checks each entry when that anode is lit.
module tb_ssd_debug_ctrl;

  localparam logic [6:0] BLK = 7'b1111111;
  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S4  = 7'b0011001;
  localparam logic [6:0] S5  = 7'b0010010;
  localparam logic [6:0] S7  = 7'b1111000;
  localparam logic [6:0] S8  = 7'b0000000;
  localparam logic [6:0] S9  = 7'b0010000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_next = 1'b0;
  logic        btn_prev = 1'b0;
  logic [12:0] value_in = '0;
  logic [3:0]  sel_out;
  logic [3:0]  anode;
  logic [6:0]  cathode;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] cat;
    logic [3:0] sel;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  ssd_debug_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .REFRESH_DIV     (2),
    .NUM_SEL         (12)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_next (btn_next),
    .btn_prev (btn_prev),
    .value_in (value_in),
    .sel_out  (sel_out),
    .anode    (anode),
    .cathode  (cathode)
  );

  always #5 clk = ~clk;

  // Monitor: compare the head entry once its digit is being driven
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && anode === exp_q[0].an) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (cathode !== e.cat) begin
          failures++;
          $display("FAIL %s cathode: got %b required %b (anode %b)", nm, cathode, e.cat, anode);
        end
        checks++;
        if (sel_out !== e.sel) begin
          failures++;
          $display("FAIL %s sel_out: got %0d required %0d", nm, sel_out, e.sel);
        end
      end
    end
  end

  task automatic push(input string nm, input logic [3:0] an, input logic [6:0] cat,
                      input logic [3:0] sel);
    exp_t e;
    e.an  = an;
    e.cat = cat;
    e.sel = sel;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Wait for the monitor to consume everything; an expired budget is a failure
  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL timeout %s: %0d entries pending, required 0", name_q[0], exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic press(input logic nxt, input logic prv, input int hold);
    @(posedge clk);
    #1;
    btn_next = nxt;
    btn_prev = prv;
    repeat (hold) @(posedge clk);
    #1;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (14) @(posedge clk);
  endtask

  task automatic settle();
    repeat (40) @(posedge clk);
  endtask

  initial begin
    logic [3:0] old_sel;
    int n;

    // 1. Reset state, then zero value
    repeat (3) @(posedge clk);
    push("reset", 4'b1110, S0, 4'd0);
    drain(3);
    @(posedge clk);
    #1 rst_n = 1'b1;
    settle();
    push("zero_d1", 4'b1101, BLK, 4'd0);
    push("zero_d3", 4'b0111, BLK, 4'd0);
    push("zero_d0", 4'b1110, S0, 4'd0);
    drain(40);

    // 2. Maximum value
    value_in = 13'd8191;
    settle();
    push("max_d3", 4'b0111, S8, 4'd0);
    push("max_d2", 4'b1011, S1, 4'd0);
    push("max_d1", 4'b1101, S9, 4'd0);
    push("max_d0", 4'b1110, S1, 4'd0);
    drain(40);

    // 3. Debounce: a short press is ignored, a long one steps once
    press(1'b1, 1'b0, 3);
    push("short_press", 4'b1110, S1, 4'd0);
    drain(40);
    press(1'b1, 1'b0, 10);
    push("long_press", 4'b1110, S1, 4'd1);
    drain(40);

    // 4. Wrapping and simultaneous steps
    press(1'b0, 1'b1, 10);
    push("prev_to0", 4'b1110, S1, 4'd0);
    drain(40);
    press(1'b0, 1'b1, 10);
    push("prev_wrap", 4'b1110, S1, 4'd11);
    drain(40);
    press(1'b1, 1'b0, 10);
    push("next_wrap", 4'b1110, S1, 4'd0);
    drain(40);
    press(1'b1, 1'b1, 10);
    push("both", 4'b1110, S1, 4'd0);
    drain(40);

    // 5. Leading-zero blanking
    value_in = 13'd7;
    settle();
    push("seven_d3", 4'b0111, BLK, 4'd0);
    push("seven_d2", 4'b1011, BLK, 4'd0);
    push("seven_d1", 4'b1101, BLK, 4'd0);
    push("seven_d0", 4'b1110, S7, 4'd0);
    drain(40);
    value_in = 13'd1005;
    settle();
    push("k_d2", 4'b1011, S0, 4'd0);
    push("k_d3", 4'b0111, S1, 4'd0);
    push("k_d1", 4'b1101, S0, 4'd0);
    push("k_d0", 4'b1110, S5, 4'd0);
    drain(40);

    // 6. Reset during SHIFT; the select change marks IDLE so timing is known
    @(posedge clk);
    #1 btn_next = 1'b1;
    old_sel = sel_out;
    n = 0;
    while (sel_out == old_sel && n < 40) begin
      @(negedge clk);
      n++;
    end
    btn_next = 1'b0;
    checks++;
    if (sel_out == old_sel) begin
      failures++;
      $display("FAIL sel_step6: got %0d required %0d", sel_out, old_sel + 4'd1);
    end
    value_in = 13'd4321;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    push("rst_mid", 4'b1110, S0, 4'd0);
    drain(3);
    #1 rst_n = 1'b1;
    repeat (9) @(posedge clk);
    push("pre_done_d3", 4'b0111, BLK, 4'd0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    push("post_done_d3", 4'b0111, S4, 4'd0);
    drain(4);
    push("rst_d2", 4'b1011, S3, 4'd0);
    push("rst_d1", 4'b1101, S2, 4'd0);
    push("rst_d0", 4'b1110, S1, 4'd0);
    drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule
